// File: rtl/psram_pkg.sv
// Shared constants and types for the PSRAM capture/dump command path.
package psram_pkg;

    // Word pointer spans 0..MEM_WORDS inclusive, so one bit wider than the word index
    localparam int PTR_W  = 23;
    localparam int ADDR_W = 23;
    localparam int DATA_W = 16;

    // Default device geometry: 8 MB part, 1 KB pages, CE-low limited bursts at 84 MHz
    localparam int DEF_MEM_WORDS       = 4194304;
    localparam int DEF_PAGE_WORDS      = 512;
    localparam int DEF_MAX_BURST_WORDS = 112;
    localparam int DEF_CMD_TIMEOUT     = 1023;

    // read_write encoding understood by the quad-SPI driver
    localparam logic [1:0] RW_NONE  = 2'd0;
    localparam logic [1:0] RW_WRITE = 2'd1;
    localparam logic [1:0] RW_READ  = 2'd2;

    // Opcodes the driver emits for the two command kinds (quad write / fast quad read)
    localparam logic [7:0] CMD_WRITE = 8'h38;
    localparam logic [7:0] CMD_READ  = 8'hEB;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT,
        RD_PRESENT
    } seq_state_t;

    // Word pointer to driver byte address; callers never pass a pointer at MEM_WORDS
    function automatic logic [ADDR_W-1:0] word_to_byte(input logic [PTR_W-1:0] w);
        return {w[PTR_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/psram_cmd_watchdog.sv
// Command timeout counter: armed when a command is issued, stopped when it completes,
// flags expiry once the driver has been silent for TIMEOUT cycles.
module psram_cmd_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic mem_clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;
    logic             running;

    // Count wait cycles from command issue; saturate at TIMEOUT so expire stays asserted
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            running <= 1'b1;
        end else if (clear) begin
            running <= 1'b0;
        end else if (running && (cnt != CNT_W'(TIMEOUT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = running && (cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/psram_stream_sequencer.sv
// Command sequencer in front of the quad-SPI PSRAM driver: drains the sample FIFO into
// PSRAM as page-safe bursts during capture, then reads words back one at a time on dump.
module psram_stream_sequencer
    import psram_pkg::*;
#(
    parameter int MEM_WORDS       = DEF_MEM_WORDS,
    parameter int PAGE_WORDS      = DEF_PAGE_WORDS,
    parameter int MAX_BURST_WORDS = DEF_MAX_BURST_WORDS,
    parameter int CMD_TIMEOUT     = DEF_CMD_TIMEOUT
) (
    input  logic              mem_clk,
    input  logic              rst,
    input  logic              qpi_on,
    input  logic              arm,
    input  logic              capture_en,
    input  logic              dump_req,
    input  logic              fifo_empty,
    input  logic              fifo_rd,
    input  logic              endcommand,
    input  logic [DATA_W-1:0] psram_rdata,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] address,
    output logic [1:0]        read_write,
    output logic              quad_start,
    output logic              burst_mode,
    output logic              fifo_empty_drv,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_valid,
    output logic              dump_done,
    output logic              mem_full,
    output logic              cmd_err
);

    localparam logic [PTR_W-1:0] MEM_LIM   = PTR_W'(MEM_WORDS);
    localparam logic [PTR_W-1:0] PAGE_LEN  = PTR_W'(PAGE_WORDS);
    localparam logic [PTR_W-1:0] BURST_LIM = PTR_W'(MAX_BURST_WORDS);

    seq_state_t       state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] burst_cnt;
    logic [PTR_W-1:0] burst_nxt;
    logic [PTR_W-1:0] room;
    logic [PTR_W-1:0] rd_nxt;
    logic             wr_start;
    logic             rd_start;
    logic             in_wait;
    logic             wd_start;
    logic             wd_clear;
    logic             wd_expire;

    // Words left before the page boundary; PAGE_WORDS is a power of two
    assign room      = PAGE_LEN - (wr_ptr & (PAGE_LEN - 1'b1));
    // A word taken in the endcommand cycle itself still belongs to this burst
    assign burst_nxt = burst_cnt + PTR_W'(fifo_rd);
    assign rd_nxt    = rd_ptr + 1'b1;

    // arm takes the cycle for itself so a start never launches from a stale pointer
    assign wr_start = qpi_on & capture_en & ~fifo_empty & ~mem_full & ~cmd_err & ~arm;
    assign rd_start = dump_req & qpi_on & ~capture_en & (wr_ptr != '0) & ~cmd_err & ~arm;

    // The driver only sees data while a write burst is open and within page/burst limits
    assign fifo_empty_drv = fifo_empty | (state != WR_WAIT) |
                            (burst_cnt >= room) | (burst_cnt >= BURST_LIM);

    assign in_wait  = (state == WR_WAIT) || (state == RD_WAIT);
    assign wd_start = (state == WR_ISSUE) || (state == RD_ISSUE);
    assign wd_clear = in_wait & (endcommand | wd_expire);

    psram_cmd_watchdog #(
        .TIMEOUT (CMD_TIMEOUT)
    ) u_watchdog (
        .mem_clk (mem_clk),
        .rst     (rst),
        .start   (wd_start),
        .clear   (wd_clear),
        .expire  (wd_expire)
    );

    // Command FSM: issues write bursts and single-word reads, owns all driver-facing registers
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            address    <= '0;
            read_write <= RW_NONE;
            quad_start <= 1'b0;
            burst_mode <= 1'b0;
            dump_data  <= '0;
            dump_valid <= 1'b0;
            dump_done  <= 1'b0;
            mem_full   <= 1'b0;
            cmd_err    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            burst_cnt  <= '0;
        end else begin
            quad_start <= 1'b0;
            dump_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        wr_ptr   <= '0;
                        mem_full <= 1'b0;
                        cmd_err  <= 1'b0;
                    end
                    if (wr_start) begin
                        address    <= word_to_byte(wr_ptr);
                        read_write <= RW_WRITE;
                        burst_mode <= 1'b1;
                        quad_start <= 1'b1;
                        burst_cnt  <= '0;
                        state      <= WR_ISSUE;
                    end else if (rd_start) begin
                        address    <= word_to_byte(rd_ptr);
                        read_write <= RW_READ;
                        burst_mode <= 1'b0;
                        quad_start <= 1'b1;
                        state      <= RD_ISSUE;
                    end
                end
                WR_ISSUE: begin
                    state <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (endcommand) begin
                        wr_ptr     <= wr_ptr + burst_nxt;
                        mem_full   <= ((wr_ptr + burst_nxt) == MEM_LIM);
                        burst_cnt  <= '0;
                        read_write <= RW_NONE;
                        burst_mode <= 1'b0;
                        state      <= IDLE;
                    end else if (wd_expire) begin
                        // Words already handed over are abandoned; the pointer stays put
                        cmd_err    <= 1'b1;
                        burst_cnt  <= '0;
                        read_write <= RW_NONE;
                        burst_mode <= 1'b0;
                        state      <= IDLE;
                    end else if (fifo_rd) begin
                        burst_cnt <= burst_nxt;
                    end
                end
                RD_ISSUE: begin
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (endcommand) begin
                        dump_data  <= psram_rdata;
                        dump_valid <= 1'b1;
                        read_write <= RW_NONE;
                        state      <= RD_PRESENT;
                    end else if (wd_expire) begin
                        cmd_err    <= 1'b1;
                        read_write <= RW_NONE;
                        rd_ptr     <= '0;
                        state      <= IDLE;
                    end
                end
                RD_PRESENT: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (rd_nxt == wr_ptr) begin
                            dump_done <= 1'b1;
                            rd_ptr    <= '0;
                            state     <= IDLE;
                        end else begin
                            rd_ptr     <= rd_nxt;
                            address    <= word_to_byte(rd_nxt);
                            read_write <= RW_READ;
                            burst_mode <= 1'b0;
                            quad_start <= 1'b1;
                            state      <= RD_ISSUE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psram_stream_sequencer.sv
// Directed bench for psram_stream_sequencer with a behavioural FIFO and quad-SPI driver model.
module tb_psram_stream_sequencer;

    logic        mem_clk = 1'b0;
    logic        rst = 1'b1;
    logic        qpi_on = 1'b0;
    logic        arm = 1'b0;
    logic        capture_en = 1'b0;
    logic        dump_req = 1'b0;
    logic        fifo_rd = 1'b0;
    logic        endcommand = 1'b0;
    logic [15:0] psram_rdata = 16'h0;
    logic        dump_ready = 1'b0;
    wire         fifo_empty;
    logic [22:0] address;
    logic [1:0]  read_write;
    logic        quad_start;
    logic        burst_mode;
    logic        fifo_empty_drv;
    logic [15:0] dump_data;
    logic        dump_valid;
    logic        dump_done;
    logic        mem_full;
    logic        cmd_err;

    psram_stream_sequencer dut (
        .mem_clk        (mem_clk),
        .rst            (rst),
        .qpi_on         (qpi_on),
        .arm            (arm),
        .capture_en     (capture_en),
        .dump_req       (dump_req),
        .fifo_empty     (fifo_empty),
        .fifo_rd        (fifo_rd),
        .endcommand     (endcommand),
        .psram_rdata    (psram_rdata),
        .dump_ready     (dump_ready),
        .address        (address),
        .read_write     (read_write),
        .quad_start     (quad_start),
        .burst_mode     (burst_mode),
        .fifo_empty_drv (fifo_empty_drv),
        .dump_data      (dump_data),
        .dump_valid     (dump_valid),
        .dump_done      (dump_done),
        .mem_full       (mem_full),
        .cmd_err        (cmd_err)
    );

    always #6 mem_clk = ~mem_clk;

    int errors = 0;
    int checks = 0;

    // FIFO model
    logic [15:0] fifo_q[$];
    int          fifo_n = 0;
    assign fifo_empty = (fifo_n == 0);

    // PSRAM contents as seen through the driver model
    logic [15:0] mem [0:4095];

    // Command log
    int          qs_cnt = 0;
    logic [22:0] qs_addr[$];
    logic [1:0]  qs_rw[$];
    logic        qs_bm[$];
    int          blen_q[$];
    int          done_cnt = 0;
    bit          drv_hold = 1'b0;
    int          exp_len[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Record every command strobe and every dump completion pulse
    always @(negedge mem_clk) begin
        if (quad_start) begin
            qs_cnt++;
            qs_addr.push_back(address);
            qs_rw.push_back(read_write);
            qs_bm.push_back(burst_mode);
        end
        if (dump_done) done_cnt++;
    end

    // Driver model: pulls one word every two cycles while the gate is open, then ends the burst
    initial begin
        int n;
        int wbase;
        forever begin
            @(negedge mem_clk);
            if (quad_start && !drv_hold) begin
                if (read_write == 2'd1) begin
                    n = 0;
                    wbase = int'(address >> 1);
                    for (int i = 0; i < 400; i++) begin
                        @(negedge mem_clk);
                        if (!fifo_empty_drv && fifo_n > 0) begin
                            fifo_rd = 1'b1;
                            @(negedge mem_clk);
                            fifo_rd = 1'b0;
                            mem[(wbase + n) % 4096] = fifo_q.pop_front();
                            fifo_n--;
                            n++;
                        end else begin
                            break;
                        end
                    end
                    endcommand = 1'b1;
                    @(negedge mem_clk);
                    endcommand = 1'b0;
                    blen_q.push_back(n);
                end else if (read_write == 2'd2) begin
                    repeat (2) @(negedge mem_clk);
                    psram_rdata = mem[int'(address >> 1) % 4096];
                    endcommand = 1'b1;
                    @(negedge mem_clk);
                    endcommand = 1'b0;
                end
            end
        end
    end

    task automatic push_words(input int count, input int first_val);
        for (int i = 0; i < count; i++) begin
            fifo_q.push_back(16'(first_val + i));
            fifo_n++;
        end
    endtask

    task automatic do_reset();
        qpi_on = 1'b0;
        capture_en = 1'b0;
        dump_ready = 1'b0;
        rst = 1'b1;
        fifo_q.delete();
        fifo_n = 0;
        repeat (3) @(negedge mem_clk);
        rst = 1'b0;
        @(negedge mem_clk);
    endtask

    task automatic wait_bursts(input string tag, input int target);
        int t;
        t = 0;
        while (blen_q.size() < target && t < 6000) begin
            @(negedge mem_clk);
            t++;
        end
        if (blen_q.size() < target) check({tag, "_timeout"}, blen_q.size(), target);
        repeat (3) @(negedge mem_clk);
    endtask

    // Compare logged bursts against exp_len[], deriving addresses from the running pointer
    task automatic check_bursts(input string tag, input int bidx, input int qidx,
                                input int ptr0, input int n);
        int p;
        p = ptr0;
        for (int i = 0; i < n; i++) begin
            check({tag, "_len"}, blen_q[bidx + i], exp_len[i]);
            check({tag, "_addr"}, qs_addr[qidx + i], p * 2);
            check({tag, "_rw"}, qs_rw[qidx + i], 1);
            check({tag, "_bm"}, qs_bm[qidx + i], 1);
            p += exp_len[i];
        end
    endtask

    typedef struct {
        logic       qpi;
        logic       cap;
        int         words;
        logic       dreq;
        int         exp_qs;
        logic       exp_fed;
        logic [1:0] exp_rw;
    } vec_t;

    initial begin
        vec_t  vt[5];
        string vn[5];
        int    bi;
        int    qi;
        int    base;
        int    d0;
        int    t;

        vt[0] = '{1'b0, 1'b1, 4, 1'b0, 0, 1'b1, 2'd0}; vn[0] = "gate_qpi_off";
        vt[1] = '{1'b1, 1'b0, 4, 1'b0, 0, 1'b1, 2'd0}; vn[1] = "gate_capture_off";
        vt[2] = '{1'b1, 1'b1, 0, 1'b0, 0, 1'b1, 2'd0}; vn[2] = "gate_fifo_empty";
        vt[3] = '{1'b1, 1'b0, 0, 1'b1, 0, 1'b1, 2'd0}; vn[3] = "dump_no_data";
        vt[4] = '{1'b1, 1'b1, 0, 1'b1, 0, 1'b1, 2'd0}; vn[4] = "dump_in_capture";

        // Reset state
        repeat (2) @(negedge mem_clk);
        check("rst_address", address, 0);
        check("rst_read_write", read_write, 0);
        check("rst_quad_start", quad_start, 0);
        check("rst_burst_mode", burst_mode, 0);
        check("rst_fifo_empty_drv", fifo_empty_drv, 1);
        check("rst_dump_valid", dump_valid, 0);
        check("rst_dump_data", dump_data, 0);
        check("rst_dump_done", dump_done, 0);
        check("rst_mem_full", mem_full, 0);
        check("rst_cmd_err", cmd_err, 0);
        rst = 1'b0;
        @(negedge mem_clk);

        // Conditions under which no command may be issued
        for (int v = 0; v < 5; v++) begin
            base = qs_cnt;
            qpi_on = vt[v].qpi;
            capture_en = vt[v].cap;
            push_words(vt[v].words, 0);
            dump_req = vt[v].dreq;
            @(negedge mem_clk);
            dump_req = 1'b0;
            repeat (4) @(negedge mem_clk);
            check({vn[v], "_qs"}, qs_cnt - base, vt[v].exp_qs);
            check({vn[v], "_fed"}, fifo_empty_drv, vt[v].exp_fed);
            check({vn[v], "_rw"}, read_write, vt[v].exp_rw);
            capture_en = 1'b0;
            qpi_on = 1'b0;
            fifo_q.delete();
            fifo_n = 0;
            @(negedge mem_clk);
        end

        // 10-word burst from 0, then fill to 500, then cross the first page boundary
        do_reset();
        qpi_on = 1'b1;
        capture_en = 1'b1;
        bi = blen_q.size();
        qi = qs_addr.size();
        push_words(10, 100);
        wait_bursts("b10", bi + 1);
        exp_len[0] = 10;
        check_bursts("b10", bi, qi, 0, 1);
        check("b10_rw_idle", read_write, 0);
        check("b10_bm_idle", burst_mode, 0);

        bi = blen_q.size();
        qi = qs_addr.size();
        push_words(490, 200);
        wait_bursts("fill500", bi + 5);
        exp_len[0] = 112; exp_len[1] = 112; exp_len[2] = 112; exp_len[3] = 112; exp_len[4] = 42;
        check_bursts("fill500", bi, qi, 10, 5);

        bi = blen_q.size();
        qi = qs_addr.size();
        push_words(40, 700);
        wait_bursts("page", bi + 2);
        exp_len[0] = 12; exp_len[1] = 28;
        check_bursts("page", bi, qi, 500, 2);
        check("page_next_addr", qs_addr[qi + 1], 23'h400);

        // Deep FIFO: bursts capped at 112 words, then clipped by the page end
        do_reset();
        qpi_on = 1'b1;
        capture_en = 1'b1;
        bi = blen_q.size();
        qi = qs_addr.size();
        push_words(612, 0);
        wait_bursts("maxburst", bi + 6);
        exp_len[0] = 112; exp_len[1] = 112; exp_len[2] = 112; exp_len[3] = 112;
        exp_len[4] = 64;  exp_len[5] = 100;
        check_bursts("maxburst", bi, qi, 0, 6);
        check("maxburst_mem_full", mem_full, 0);

        // Capture 5 words, then dump them with a stalling consumer
        do_reset();
        qpi_on = 1'b1;
        capture_en = 1'b1;
        bi = blen_q.size();
        push_words(5, 1);
        wait_bursts("dcap", bi + 1);
        capture_en = 1'b0;
        repeat (2) @(negedge mem_clk);
        qi = qs_addr.size();
        d0 = done_cnt;
        dump_req = 1'b1;
        @(negedge mem_clk);
        dump_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            t = 0;
            while (!dump_valid && t < 50) begin
                @(negedge mem_clk);
                t++;
            end
            check("dump_valid_rise", dump_valid, 1);
            repeat (3) @(negedge mem_clk);
            check("dump_valid_hold", dump_valid, 1);
            check("dump_data", dump_data, k + 1);
            dump_ready = 1'b1;
            @(negedge mem_clk);
            dump_ready = 1'b0;
            check("dump_valid_drop", dump_valid, 0);
        end
        repeat (4) @(negedge mem_clk);
        check("dump_done_count", done_cnt - d0, 1);
        check("dump_read_count", qs_addr.size() - qi, 5);
        for (int k = 0; k < 5; k++) begin
            check("dump_rd_addr", qs_addr[qi + k], 2 * k);
            check("dump_rd_rw", qs_rw[qi + k], 2);
            check("dump_rd_bm", qs_bm[qi + k], 0);
        end

        // Driver never completes: timeout, no further commands, recovery via arm
        do_reset();
        drv_hold = 1'b1;
        qpi_on = 1'b1;
        capture_en = 1'b1;
        base = qs_cnt;
        push_words(3, 50);
        t = 0;
        while (qs_cnt == base && t < 20) begin
            @(negedge mem_clk);
            t++;
        end
        check("to_issue", qs_cnt - base, 1);
        repeat (1000) @(negedge mem_clk);
        check("to_early", cmd_err, 0);
        t = 0;
        while (!cmd_err && t < 100) begin
            @(negedge mem_clk);
            t++;
        end
        check("to_cmd_err", cmd_err, 1);
        check("to_rw_cleared", read_write, 0);
        base = qs_cnt;
        repeat (30) @(negedge mem_clk);
        check("to_no_issue", qs_cnt - base, 0);
        drv_hold = 1'b0;
        bi = blen_q.size();
        qi = qs_addr.size();
        arm = 1'b1;
        @(negedge mem_clk);
        arm = 1'b0;
        wait_bursts("arm", bi + 1);
        check("arm_cmd_err", cmd_err, 0);
        exp_len[0] = 3;
        check_bursts("arm", bi, qi, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop if the run ever stalls
    initial begin
        #(12 * 60000);
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule
